// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake receive FIFO: default sizing and the
// protocol-checker state encoding.
package handshake_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic {
        CHK_IDLE  = 1'b0,
        CHK_STALL = 1'b1
    } chk_state_t;

endpackage

// File: rtl/handshake_chk.sv
// Upstream protocol checker: once valid is stalled by ready=0, valid must stay
// high and data must stay stable until the transfer completes.
module handshake_chk
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic              proto_err
);

    chk_state_t        state;
    chk_state_t        state_next;
    logic [DATA_W-1:0] cap_data;
    logic              violation;
    logic              capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CHK_IDLE;
            cap_data  <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                cap_data <= data;
            end
            if (violation) begin
                proto_err <= 1'b1;
            end
        end
    end

    // A changed payload counts as a violation even if ready rises in the same cycle.
    always_comb begin
        state_next = state;
        violation  = 1'b0;
        capture    = 1'b0;
        case (state)
            CHK_IDLE: begin
                if (valid && !ready) begin
                    state_next = CHK_STALL;
                    capture    = 1'b1;
                end
            end
            CHK_STALL: begin
                if (!valid || (data != cap_data)) begin
                    violation  = 1'b1;
                    state_next = CHK_IDLE;
                end else if (ready) begin
                    state_next = CHK_IDLE;
                end
            end
            default: state_next = CHK_IDLE;
        endcase
    end

endmodule

// File: rtl/handshake_rx_fifo.sv
// First-word fall-through receive FIFO with an upstream protocol checker.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module handshake_rx_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        data,
    input  logic                     valid,
    output logic                     ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    // ready and out_valid come only from the registered count.
    assign ready     = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = valid && ready && !reset;
    assign pop       = out_valid && out_ready && !reset;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    handshake_chk #(
        .DATA_W (DATA_W)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .ready     (ready),
        .data      (data),
        .proto_err (proto_err)
    );

endmodule
